// File: rtl/osc_div_pkg.sv
// Shared types for the oscillator clock divider.
// Optional SYNC_IN realignment is built when OSC_DIV_SYNC_EN is defined.
package osc_div_pkg;

  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  localparam int DIV_W_DEF      = 8;
  localparam int MIN_DIV_ACTIVE = 1;

  typedef struct packed {
    logic                 pend;
    logic [DIV_W_DEF-1:0] pdiv;
    logic [DIV_W_DEF-1:0] cur;
  } ch_cfg_t;

endpackage

// File: rtl/osc_clk_div_gen_chan.sv
// One divider channel: period counter, duty, boundary-aligned ratio apply.
// The sync input realigns the channel when OSC_DIV_SYNC_EN is built in.
module osc_div_chan
  import osc_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             go,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             div_out,
  output logic             en_out,
  output logic             active,
  output logic             pend
);

  typedef logic [DIV_W-1:0] r_t;

  ch_cfg_t cfg, cfg_d;
  r_t      cnt, cnt_d, cur, n_nxt, half;
  logic    last, apply;
  logic    div_d, en_d, div_q, en_q;

  // Next count/ratio; outputs are precomputed so they line up with cnt.
  always_comb begin
    cur   = r_t'(cfg.cur);
    last  = (cur <= r_t'(MIN_DIV_ACTIVE))
         || (cnt == cur - r_t'(1));
    apply = run && cfg.pend && (sync || last);
    n_nxt = apply ? r_t'(cfg.pdiv) : cur;
    cnt_d = (!run || sync || last) ? '0 : cnt + r_t'(1);
    half  = n_nxt >> 1;
    div_d = go && ((n_nxt == r_t'(MIN_DIV_ACTIVE))
                   || (cnt_d < half));
    en_d  = go && (n_nxt != '0)
                && (cnt_d == n_nxt - r_t'(1));
    cfg_d     = cfg;
    cfg_d.cur = DIV_W_DEF'(n_nxt);
    if (apply) cfg_d.pend = 1'b0;
    if (wr) begin
      cfg_d.pend = 1'b1;
      cfg_d.pdiv = DIV_W_DEF'(wr_div);
    end
  end

  // Channel state and registered clock/enable outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg.pend <= 1'b0;
      cfg.pdiv <= '0;
      cfg.cur  <= DIV_W_DEF'(DEFAULT_DIV);
      cnt      <= '0;
      div_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      cfg   <= cfg_d;
      cnt   <= cnt_d;
      div_q <= div_d;
      en_q  <= en_d;
    end
  end

  assign div_out = div_q;
  assign en_out  = en_q & ~sync;
  assign active  = (cur != '0);
  assign pend    = cfg.pend;

endmodule

// File: rtl/osc_clk_div_gen.sv
// Multi-channel divider on the 160 MHz RC oscillator with settle window.
// Define OSC_DIV_SYNC_EN to add SYNC_IN for all-channel realignment.
module osc_clk_div_gen
  import osc_div_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = DIV_W_DEF,
  parameter int DEFAULT_DIV    = 2,
  parameter int STARTUP_CYCLES = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef OSC_DIV_SYNC_EN
  input  logic              SYNC_IN,
`endif
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  output logic              CFG_ERR,
  output logic              OSC_READY,
  output logic [NUM_CH-1:0] CLK_DIV_OUT,
  output logic [NUM_CH-1:0] CLK_EN_OUT,
  output logic [NUM_CH-1:0] CH_ACTIVE
);

  localparam int SC_W =
    (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  state_t            state, state_d;
  logic [SC_W-1:0]   scnt, scnt_d;
  logic              run, go, sync;
  logic              acc, ch_ok, busy, err_q;
  logic [NUM_CH-1:0] pend, wr;

  // Settle-window FSM next state.
  always_comb begin
    state_d = state;
    scnt_d  = scnt;
    unique case (state)
      ST_STARTUP: begin
        if (scnt == SC_W'(STARTUP_CYCLES - 1))
          state_d = ST_RUN;
        else
          scnt_d = scnt + SC_W'(1);
      end
      ST_RUN: state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_STARTUP;
      scnt  <= '0;
    end else begin
      state <= state_d;
      scnt  <= scnt_d;
    end
  end

  assign run       = (state == ST_RUN);
  assign go        = (state_d == ST_RUN);
  assign OSC_READY = run;

`ifdef OSC_DIV_SYNC_EN
  assign sync = SYNC_IN & run;
`else
  assign sync = 1'b0;
`endif

  // Config decode: ready per target channel, write strobes.
  always_comb begin
    ch_ok = int'(CFG_CH) < NUM_CH;
    busy  = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (CFG_CH == CH_W'(i)) busy = pend[i];
    CFG_READY = run && !busy;
    acc       = CFG_VALID && CFG_READY;
    wr        = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr[i] = acc && (CFG_CH == CH_W'(i));
  end

  // Error pulse for an accepted out-of-range channel.
  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= acc && !ch_ok;
  end

  assign CFG_ERR = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    osc_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .run     (run),
      .go      (go),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (CFG_DIV),
      .div_out (CLK_DIV_OUT[g]),
      .en_out  (CLK_EN_OUT[g]),
      .active  (CH_ACTIVE[g]),
      .pend    (pend[g])
    );
  end

endmodule
